// File: rtl/mux_scan_ctrl_if.sv
// Sample stream and mux-select bundle between the scan sequencer and the 8:1 channel mux.
// The master drives select and captured samples; the slave returns mux output and ready.
interface mux_scan_ctrl_if #(
  parameter int unsigned W = 3
);
  logic [2:0]   s;
  logic [W-1:0] y_in;
  logic [W-1:0] out_data;
  logic [2:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output s,
    output out_data,
    output out_ch,
    output out_valid,
    input  y_in,
    input  out_ready
  );

  modport slave (
    input  s,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output y_in,
    output out_ready
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan sequencer for an 8:1 mux: selects each enabled channel, waits DWELL
// cycles, captures the mux output and offers it as a (channel, data) sample.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            en_mask,
  output logic                  busy,
  output logic                  frame_done,
  mux_scan_ctrl_if.master       bus
);

  localparam logic [7:0] CntLoad = 8'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e       state_q;
  logic [7:0]   mask_q;
  logic [7:0]   cnt_q;
  logic [2:0]   s_q;
  logic [W-1:0] out_data_q;
  logic [2:0]   out_ch_q;
  logic         out_valid_q;
  logic         frame_done_q;
  logic         stop_pend_q;
  logic [2:0]   nxt_ch;

  // Next enabled channel above cur, wrapping; returns cur itself for a single-channel mask.
  function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] idx;
    logic       found;
    next_ch = cur;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [2:0] first_ch(input logic [7:0] mask);
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) first_ch = 3'(i);
    end
  endfunction

  always_comb begin
    nxt_ch = next_ch(mask_q, s_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mask_q       <= 8'd0;
      cnt_q        <= 8'd0;
      s_q          <= 3'd0;
      out_data_q   <= '0;
      out_ch_q     <= 3'd0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // stop wins over a simultaneous start
          if (start && !stop && (en_mask != 8'd0)) begin
            mask_q      <= en_mask;
            s_q         <= first_ch(en_mask);
            cnt_q       <= CntLoad;
            stop_pend_q <= 1'b0;
            state_q     <= StSettle;
          end
        end
        StSettle: begin
          if (stop) begin
            state_q <= StIdle;
          end else if (cnt_q == 8'd0) begin
            out_data_q  <= bus.y_in;
            out_ch_q    <= s_q;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StHold: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q  <= 1'b0;
            s_q          <= nxt_ch;
            frame_done_q <= (nxt_ch <= s_q);
            cnt_q        <= CntLoad;
            stop_pend_q  <= 1'b0;
            state_q      <= (stop_pend_q || stop) ? StIdle : StSettle;
          end else if (stop) begin
            stop_pend_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = (state_q != StIdle);
  assign frame_done    = frame_done_q;
  assign bus.s         = s_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule
